// File: rtl/core_round_scheduler.sv
// rtl/core_round_scheduler.sv - routes tasks to mining cores, tracks round completion, serialises found events
module core_round_scheduler #(
  parameter int          CORES_QNT   = 4,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1000000
) (
  input  logic                 i_clk,
  input  logic                 i_n_reset,
  input  logic                 i_task_nf,
  input  logic [15:0]          i_task_core_num,
  input  logic                 i_gen_term,
  input  logic [CORES_QNT-1:0] i_core_done,
  input  logic [CORES_QNT-1:0] i_core_found,
  output logic [CORES_QNT-1:0] o_core_load,
  output logic                 o_core_abort,
  output logic                 o_tasks_sr_ack,
  output logic                 o_found_nf,
  output logic [3:0]           o_found_core_num,
  output logic [31:0]          o_rounds_qnt,
  output logic                 o_timeout,
  output logic                 o_dup_err,
  output logic                 o_bf
);

  localparam logic [CORES_QNT-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, ACK} state_t;

  state_t               state, state_next;
  logic [CORES_QNT-1:0] loaded, loaded_next;
  logic [CORES_QNT-1:0] pending, pending_next;
  logic [CORES_QNT-1:0] load_next;
  logic [CORES_QNT-1:0] task_sel;
  logic [CORES_QNT-1:0] found_mask, found_pick;
  logic [31:0]          tmo_cnt, tmo_cnt_next;
  logic [31:0]          rounds_next;
  logic                 abort_next, ack_next, timeout_next, dup_next;
  logic [3:0]           found_num;

  // Out-of-range core numbers simply match no bit, so they produce no strobe.
  always_comb begin
    task_sel = '0;
    for (int k = 0; k < CORES_QNT; k++)
      task_sel[k] = i_task_nf && (i_task_core_num == 16'(k));
  end

  always_comb begin
    state_next   = state;
    loaded_next  = loaded;
    pending_next = pending;
    tmo_cnt_next = tmo_cnt;
    load_next    = '0;
    abort_next   = 1'b0;
    ack_next     = 1'b0;
    timeout_next = o_timeout;
    dup_next     = o_dup_err;
    rounds_next  = o_rounds_qnt;
    if (i_gen_term) begin
      abort_next   = 1'b1;
      state_next   = IDLE;
      loaded_next  = '0;
      pending_next = '0;
      tmo_cnt_next = '0;
    end else begin
      case (state)
        IDLE: begin
          loaded_next  = '0;
          pending_next = '0;
          tmo_cnt_next = '0;
          if (i_task_nf) begin
            load_next    = task_sel;
            loaded_next  = task_sel;
            pending_next = task_sel;
            state_next   = LOAD;
          end
        end
        LOAD: begin
          if ((task_sel & loaded) != '0) begin
            dup_next = 1'b1;
          end else begin
            load_next    = task_sel;
            loaded_next  = loaded | task_sel;
            pending_next = pending | task_sel;
          end
          if (loaded == ALL_ONES)
            state_next = RUN;
        end
        RUN: begin
          tmo_cnt_next = tmo_cnt + 32'd1;
          pending_next = pending & ~i_core_done;
          // A timed-out round is closed like a finished one so the generator never stalls.
          if (pending_next == '0 || tmo_cnt_next == TIMEOUT_CYC) begin
            if (tmo_cnt_next == TIMEOUT_CYC)
              timeout_next = 1'b1;
            state_next   = ACK;
            ack_next     = 1'b1;
            rounds_next  = o_rounds_qnt + 32'd1;
            loaded_next  = '0;
            pending_next = '0;
            tmo_cnt_next = '0;
          end
        end
        ACK:     state_next = LOAD;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state          <= IDLE;
      loaded         <= '0;
      pending        <= '0;
      tmo_cnt        <= '0;
      o_core_load    <= '0;
      o_core_abort   <= 1'b0;
      o_tasks_sr_ack <= 1'b0;
      o_rounds_qnt   <= '0;
      o_timeout      <= 1'b0;
      o_dup_err      <= 1'b0;
    end else begin
      state          <= state_next;
      loaded         <= loaded_next;
      pending        <= pending_next;
      tmo_cnt        <= tmo_cnt_next;
      o_core_load    <= load_next;
      o_core_abort   <= abort_next;
      o_tasks_sr_ack <= ack_next;
      o_rounds_qnt   <= rounds_next;
      o_timeout      <= timeout_next;
      o_dup_err      <= dup_next;
    end
  end

  // Descending scan so the lowest set index is the one left selected.
  always_comb begin
    found_pick = '0;
    found_num  = 4'd0;
    for (int k = CORES_QNT - 1; k >= 0; k--) begin
      if (found_mask[k]) begin
        found_pick    = '0;
        found_pick[k] = 1'b1;
        found_num     = 4'(k);
      end
    end
  end

  // A fresh pulse on the bit being reported is ORed back in after the clear.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset)
      found_mask <= '0;
    else
      found_mask <= (found_mask & ~found_pick) | i_core_found;
  end

  assign o_found_nf       = |found_mask;
  assign o_found_core_num = found_num;
  assign o_bf             = (state != IDLE);

endmodule

// File: tb/tb_core_round_scheduler.sv
// tb/tb_core_round_scheduler.sv - directed self-checking bench for core_round_scheduler
module tb_core_round_scheduler;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        task_nf;
  logic [15:0] task_core_num;
  logic        gen_term;
  logic [3:0]  core_done;
  logic [3:0]  core_found;
  logic [3:0]  core_load;
  logic        core_abort;
  logic        tasks_sr_ack;
  logic        found_nf;
  logic [3:0]  found_core_num;
  logic [31:0] rounds_qnt;
  logic        timeout;
  logic        dup_err;
  logic        bf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  core_round_scheduler #(.CORES_QNT(4), .TIMEOUT_CYC(32'd16)) dut (
    .i_clk            (clk),
    .i_n_reset        (n_reset),
    .i_task_nf        (task_nf),
    .i_task_core_num  (task_core_num),
    .i_gen_term       (gen_term),
    .i_core_done      (core_done),
    .i_core_found     (core_found),
    .o_core_load      (core_load),
    .o_core_abort     (core_abort),
    .o_tasks_sr_ack   (tasks_sr_ack),
    .o_found_nf       (found_nf),
    .o_found_core_num (found_core_num),
    .o_rounds_qnt     (rounds_qnt),
    .o_timeout        (timeout),
    .o_dup_err        (dup_err),
    .o_bf             (bf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_task(input int num);
    task_nf       = 1'b1;
    task_core_num = 16'(num);
    tick();
    task_nf       = 1'b0;
  endtask

  initial begin
    int n;
    n_reset       = 1'b0;
    task_nf       = 1'b0;
    task_core_num = 16'd0;
    gen_term      = 1'b0;
    core_done     = 4'd0;
    core_found    = 4'd0;
    tick();
    tick();
    check_eq("rst_load", 32'(core_load), 32'h0);
    check_eq("rst_abort", 32'(core_abort), 32'h0);
    check_eq("rst_ack", 32'(tasks_sr_ack), 32'h0);
    check_eq("rst_found", 32'(found_nf), 32'h0);
    check_eq("rst_rounds", rounds_qnt, 32'h0);
    check_eq("rst_flags", {30'd0, timeout, dup_err}, 32'h0);
    check_eq("rst_bf", 32'(bf), 32'h0);
    n_reset = 1'b1;
    tick();

    // round 1: load all cores in order
    for (int i = 0; i < 4; i++) begin
      send_task(i);
      check_eq("load_onehot", 32'(core_load), 32'(1 << i));
      check_eq("load_bf", 32'(bf), 32'h1);
    end
    tick();
    check_eq("run_no_load", 32'(core_load), 32'h0);

    // dones 2, 0, then 1 and 3 together
    core_done = 4'b0100; tick();
    check_eq("ack_early_a", 32'(tasks_sr_ack), 32'h0);
    core_done = 4'b0001; tick();
    check_eq("ack_early_b", 32'(tasks_sr_ack), 32'h0);
    core_done = 4'b1010; tick();
    core_done = 4'b0000;
    check_eq("ack_pulse", 32'(tasks_sr_ack), 32'h1);
    check_eq("rounds_1", rounds_qnt, 32'd1);
    tick();
    check_eq("ack_single", 32'(tasks_sr_ack), 32'h0);
    check_eq("bf_after_ack", 32'(bf), 32'h1);
    send_task(0);
    check_eq("reload_0", 32'(core_load), 32'h1);

    // out-of-range and duplicate loads
    send_task(4);
    check_eq("range_no_load", 32'(core_load), 32'h0);
    send_task(1);
    check_eq("load_1", 32'(core_load), 32'h2);
    check_eq("dup_clear", 32'(dup_err), 32'h0);
    send_task(1);
    check_eq("dup_no_load", 32'(core_load), 32'h0);
    check_eq("dup_set", 32'(dup_err), 32'h1);
    send_task(2);
    check_eq("load_2", 32'(core_load), 32'h4);
    send_task(3);
    check_eq("load_3", 32'(core_load), 32'h8);
    tick();

    // abort with cores 2 and 3 still pending
    core_done = 4'b0011; tick();
    core_done = 4'b0000;
    gen_term  = 1'b1; tick();
    gen_term  = 1'b0;
    check_eq("abort_pulse", 32'(core_abort), 32'h1);
    check_eq("abort_no_ack", 32'(tasks_sr_ack), 32'h0);
    check_eq("abort_idle", 32'(bf), 32'h0);
    check_eq("abort_rounds", rounds_qnt, 32'd1);
    check_eq("abort_dup_kept", 32'(dup_err), 32'h1);
    tick();
    check_eq("abort_single", 32'(core_abort), 32'h0);
    check_eq("abort_still_no_ack", 32'(tasks_sr_ack), 32'h0);

    // found serialisation
    core_found = 4'b1010; tick();
    core_found = 4'b0000;
    check_eq("found_a_nf", 32'(found_nf), 32'h1);
    check_eq("found_a_num", 32'(found_core_num), 32'd1);
    tick();
    check_eq("found_b_nf", 32'(found_nf), 32'h1);
    check_eq("found_b_num", 32'(found_core_num), 32'd3);
    tick();
    check_eq("found_empty", 32'(found_nf), 32'h0);
    core_found = 4'b0101; tick();
    core_found = 4'b0100;
    check_eq("merge_num0", 32'(found_core_num), 32'd0);
    tick();
    core_found = 4'b0000;
    check_eq("merge_num2", 32'(found_core_num), 32'd2);
    check_eq("merge_nf2", 32'(found_nf), 32'h1);
    tick();
    check_eq("merge_single", 32'(found_nf), 32'h0);
    core_found = 4'b0100; tick();
    check_eq("win_first", 32'(found_core_num), 32'd2);
    tick();
    core_found = 4'b0000;
    check_eq("win_again_nf", 32'(found_nf), 32'h1);
    check_eq("win_again_num", 32'(found_core_num), 32'd2);
    tick();
    check_eq("win_done", 32'(found_nf), 32'h0);

    // timeout round
    for (int i = 0; i < 4; i++) begin
      send_task(i);
      check_eq("tmo_load", 32'(core_load), 32'(1 << i));
    end
    check_eq("tmo_clear", 32'(timeout), 32'h0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!tasks_sr_ack && n < 40);
    check_eq("tmo_latency", 32'(n), 32'd17);
    check_eq("tmo_flag", 32'(timeout), 32'h1);
    check_eq("tmo_rounds", rounds_qnt, 32'd2);
    tick();

    // asynchronous reset in the middle of a round
    for (int i = 0; i < 4; i++) send_task(i);
    tick();
    core_found = 4'b0010; tick();
    core_found = 4'b0000;
    check_eq("pre_rst_found", 32'(found_nf), 32'h1);
    check_eq("pre_rst_bf", 32'(bf), 32'h1);
    #2;
    n_reset = 1'b0;
    #1;
    check_eq("arst_rounds", rounds_qnt, 32'h0);
    check_eq("arst_flags", {30'd0, timeout, dup_err}, 32'h0);
    check_eq("arst_bf", 32'(bf), 32'h0);
    check_eq("arst_found", 32'(found_nf), 32'h0);
    check_eq("arst_pulses", {29'd0, core_abort, tasks_sr_ack, |core_load}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
